// File: rtl/seq_mult32_if.sv
// Operand/product handshake bundle for seq_mult32.
// Each side transfers on a rising edge where its valid and ready are both high.
interface seq_mult32_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               hi_nz;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, hi_nz
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, hi_nz
  );
endinterface

// File: rtl/seq_mult32.sv
// Sequential unsigned shift-add multiplier: retires one multiplier bit per cycle
// through a single WIDTH-bit adder. o_state exposes the FSM for debug.
module seq_mult32 #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_mult32_if.slave bus,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [5:0] LAST_COUNT = 6'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [5:0]         r_count;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_product;
  logic               r_hi_nz;

  logic               w_zero_op;
  logic               w_last;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_zero_op = EARLY_ZERO && ((bus.a == '0) || (bus.b == '0));
  assign w_last    = (r_count == LAST_COUNT);

  // The carry-out lands in acc_hi's MSB after the shift, so the product is exact.
  assign w_addend   = r_acc_lo[0] ? r_mcand : '0;
  assign w_sum      = {1'b0, r_acc_hi} + {1'b0, w_addend};
  assign w_acc_next = {w_sum, r_acc_lo[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_next_state = w_zero_op ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_mcand   <= '0;
      r_product <= '0;
      r_hi_nz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_mcand  <= bus.a;
            r_count  <= '0;
            r_acc_hi <= '0;
            if (w_zero_op) begin
              r_acc_lo  <= '0;
              r_product <= '0;
              r_hi_nz   <= 1'b0;
            end else begin
              r_acc_lo <= bus.b;
            end
          end
        end
        S_BUSY: begin
          r_acc_hi <= w_acc_next[2*WIDTH-1:WIDTH];
          r_acc_lo <= w_acc_next[WIDTH-1:0];
          r_count  <= r_count + 6'd1;
          // Result register only updates on the final step, so it holds through IDLE/BUSY.
          if (w_last) begin
            r_product <= w_acc_next;
            r_hi_nz   <= |w_acc_next[2*WIDTH-1:WIDTH];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.product   = r_product;
  assign bus.hi_nz     = r_hi_nz;
  assign o_state       = r_state;

endmodule

// File: tb/tb_seq_mult32.sv
// Directed and randomised checks of seq_mult32 against hand-computed and reference products.
module tb_seq_mult32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_mult32_if #(.WIDTH(32)) mif();
  seq_mult32_if #(.WIDTH(32)) zif();
  logic [1:0] st;
  logic [1:0] zst;

  seq_mult32 #(.WIDTH(32), .EARLY_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(mif.slave), .o_state(st)
  );

  seq_mult32 #(.WIDTH(32), .EARLY_ZERO(1'b0)) dut_full (
    .clk(clk), .rst_n(rst_n), .bus(zif.slave), .o_state(zst)
  );

  int checks = 0;
  int failures = 0;
  int retired = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge with the DUT idle; returns on the negedge after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    check("in_ready_before_issue", 64'(mif.in_ready), 64'd1);
    mif.a = a;
    mif.b = b;
    mif.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mif.in_valid = 1'b0;
  endtask

  // n counts edges after the accept edge until out_valid is seen.
  task automatic wait_done(output int n);
    n = 0;
    while (!mif.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_seen", 64'(mif.out_valid), 64'd1);
  endtask

  task automatic retire();
    mif.out_ready = 1'b1;
    @(negedge clk);
    mif.out_ready = 1'b0;
    retired++;
    check("out_valid_after_retire", 64'(mif.out_valid), 64'd0);
    check("in_ready_after_retire", 64'(mif.in_ready), 64'd1);
  endtask

  task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int exp_lat);
    int n;
    issue(a, b);
    wait_done(n);
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_product"}, mif.product, exp);
    check({tag, "_hi_nz"}, 64'(mif.hi_nz), 64'(|exp[63:32]));
    retire();
  endtask

  initial begin
    int n;
    int gap;
    int hold;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] e;

    mif.in_valid = 1'b0; mif.a = '0; mif.b = '0; mif.out_ready = 1'b0;
    zif.in_valid = 1'b0; zif.a = '0; zif.b = '0; zif.out_ready = 1'b0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(mif.in_ready), 64'd1);
    check("rst_out_valid", 64'(mif.out_valid), 64'd0);
    check("rst_product", mif.product, 64'd0);
    check("rst_hi_nz", 64'(mif.hi_nz), 64'd0);
    check("rst_state", 64'(st), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Small product, then product must persist into IDLE
    run_mult("small", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 32);
    check("product_held_idle", mif.product, 64'hF);

    // Worst-case carries
    run_mult("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32);
    run_mult("msb_x2", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 32);

    // Zero operands with early completion
    run_mult("zero_a_early", 32'd0, 32'h1234_5678, 64'd0, 0);
    run_mult("zero_b_early", 32'h1234_5678, 32'd0, 64'd0, 0);

    // Zero operand on the instance without early completion
    zif.a = 32'd0; zif.b = 32'h1234_5678; zif.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    zif.in_valid = 1'b0;
    n = 0;
    while (!zif.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("zero_full_latency", 64'(n), 64'd32);
    check("zero_full_product", zif.product, 64'd0);
    check("zero_full_hi_nz", 64'(zif.hi_nz), 64'd0);
    zif.out_ready = 1'b1;
    @(negedge clk);
    zif.out_ready = 1'b0;
    check("zero_full_in_ready", 64'(zif.in_ready), 64'd1);

    // Backpressure with an ignored request during the hold
    issue(32'd7, 32'd9);
    wait_done(n);
    check("bp_latency", 64'(n), 64'd32);
    mif.a = 32'd2; mif.b = 32'd2; mif.in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("bp_product", mif.product, 64'd63);
      check("bp_in_ready", 64'(mif.in_ready), 64'd0);
      check("bp_out_valid", 64'(mif.out_valid), 64'd1);
    end
    mif.in_valid = 1'b0;
    retire();
    run_mult("after_bp", 32'd2, 32'd2, 64'd4, 32);

    // Reset at iteration 17
    issue(32'hDEAD_BEEF, 32'h0000_1000);
    repeat (16) @(negedge clk);
    check("midrst_busy", 64'(st), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_state", 64'(st), 64'd0);
    check("midrst_product", mif.product, 64'd0);
    check("midrst_out_valid", 64'(mif.out_valid), 64'd0);
    check("midrst_in_ready", 64'(mif.in_ready), 64'd1);
    run_mult("after_rst", 32'd6, 32'd7, 64'd42, 32);

    // Random pairs with random gaps and backpressure
    retired = 0;
    for (int i = 0; i < 1000; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      case ($urandom_range(0, 15))
        0: ra = 32'd0;
        1: ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 15))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      exp_q.push_back(64'(ra) * 64'(rb));
      issue(ra, rb);
      wait_done(n);
      check("rand_latency", 64'(n), ((ra == 0) || (rb == 0)) ? 64'd0 : 64'd32);
      hold = $urandom_range(0, 3);
      repeat (hold) @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rand_product", mif.product, e);
        check("rand_hi_nz", 64'(mif.hi_nz), 64'(|e[63:32]));
      end
      retire();
    end
    check("rand_queue_empty", 64'(exp_q.size()), 64'd0);
    check("rand_retired", 64'(retired), 64'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_mult32.md
Name: seq_mult32

Overview:
- Sequential unsigned 32x32 -> 64 shift-add multiplier for the arithmetic datapath.
- Retires one multiplier bit per cycle through a single 32-bit ripple/skip-class adder (sum plus carry-out).
- Sits upstream of the 32-bit adder stage, which consumes its low word, and downstream of operand registers.
- Uses valid/ready handshakes on both sides so it can be stalled by either neighbour.

Parameters:
- WIDTH, 32, operand width. Fixed at 32 to match the adder; any other value is unsupported.
- EARLY_ZERO, 1, if 1, a zero operand skips iteration and completes in 1 cycle; if 0, every operation takes the full iteration count.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  32  multiplicand, unsigned.
- b  input  32  multiplier, unsigned.
- out_valid  output  1  product valid (high only in DONE).
- out_ready  input  1  consumer accepts product.
- product  output  64  a*b.
- hi_nz  output  1  product[63:32] != 0, i.e. the result does not fit in 32 bits.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-low.
- Reset, sampled on a clk edge with rst_n=0:
  - state=IDLE, count=0, acc_hi=0, acc_lo=0, mcand=0.
  - Outputs: in_ready=1, out_valid=0, product=0, hi_nz=0.
- Reset mid-operation (BUSY or DONE) aborts the operation. No product is ever presented for the aborted operand pair.
- States:
  - IDLE: in_ready=1.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=0.
- IDLE transitions:
  - On an edge with in_valid=1: mcand<=a, acc_lo<=b, acc_hi<=0, count<=0, state<=BUSY.
  - If EARLY_ZERO=1 and (a==0 or b==0): instead acc_hi<=0, acc_lo<=0, state<=DONE.
- BUSY, each edge:
  - {c,s} = acc_hi + (acc_lo[0] ? mcand : 0), 33-bit result, carry-in 0.
  - {acc_hi,acc_lo} <= {c, s, acc_lo[31:1]}, a logical right shift of the 65-bit {c,s,acc_lo}.
  - count<=count+1. count is 6 bits.
  - On the edge where count==31 (the 32nd iteration): state<=DONE.
- DONE:
  - product={acc_hi,acc_lo}; hi_nz=|acc_hi. Both are stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1: state<=IDLE.
  - product stays at its last value; it is not cleared.
- Latency:
  - The accept edge is edge 0. out_valid is high after edge 32, so the product is visible 32 cycles after accept.
  - With the early-zero path, out_valid is high after edge 0.
- Throughput:
  - A new pair cannot be accepted on the same edge that DONE retires; IDLE lasts at least one cycle.
  - Minimum issue interval is 34 cycles, or 2 cycles for an early-zero pair.
- No overflow is possible: the 64-bit product is exact.
  - The adder carry must be captured into acc_hi[31] each iteration.
  - Dropping that carry is a bug, caught by the all-ones test.
- in_valid while BUSY or DONE is ignored. Operands are not latched, and the upstream must hold them.
- out_ready while not DONE is ignored.
- product and hi_nz are driven from registers only; there is no combinational path from inputs to outputs.

Test Plan:
- Small product: reset, then a=3, b=5, in_valid for 1 cycle, out_ready=1.
  - Expect out_valid exactly 32 cycles after accept, product=0x0000_0000_0000_000F, hi_nz=0, and in_ready back high the next cycle.
- Worst-case carries: a=b=0xFFFF_FFFF.
  - Expect product=0xFFFF_FFFE_0000_0001, hi_nz=1.
  - Also a=0x8000_0000, b=2: expect product=0x0000_0001_0000_0000, hi_nz=1.
- Zero operand: a=0, b=0x1234_5678.
  - With EARLY_ZERO=1: expect out_valid 1 cycle after accept, product=0.
  - With EARLY_ZERO=0: expect out_valid after 32 cycles, product=0.
- Backpressure: a=7, b=9, hold out_ready=0 for 10 cycles after out_valid.
  - Expect product=63 held stable and in_ready=0 throughout.
  - A new in_valid (a=2, b=2) presented during the hold is ignored.
  - After out_ready=1, the next accepted pair gives 4.
- Reset mid-operation: assert rst_n=0 at iteration 17 of a=0xDEAD_BEEF, b=0x1000.
  - Expect state IDLE, product=0, out_valid=0, in_ready=1 after that edge.
  - A subsequent a=6, b=7 yields 42.
- Random: 1000 random operand pairs with random in_valid and out_ready gaps, compared against a 64-bit reference multiply.
  - Expect every product to match, with no lost or duplicated results.
